// File: rtl/dsc_sched_pkg.sv
// Shared types and sizing helpers for the multiplier job scheduler.
package dsc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int res_width(input int data_width, input int num_inputs);
    return data_width * num_inputs + 1;
  endfunction

  // Worst-case core latency for an iterative multiplier plus slack.
  function automatic int timeout_cycles(input int data_width, input int num_inputs);
    return (1 << (data_width * num_inputs)) + 16;
  endfunction

endpackage

// File: rtl/dsc_rr_arb.sv
// Round-robin arbiter: picks the first asserted request after last_grant, wrapping.
module dsc_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  always_comb begin : sel
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_idx  = IW'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsc_mul_sched.sv
// Job scheduler: arbitrates requesters onto one multiplier core, guards the
// core with a run timeout and returns each result with the requester id.
//
// state | meaning
// IDLE  | arbitrating, req_ready driven by the round-robin winner
// CLEAR | one-cycle synchronous clear of the core, operands held
// RUN   | core enabled, run counter advancing toward TIMEOUT-1
// RESP  | result presented until resp_ready
module dsc_mul_sched
  import dsc_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int NUM_REQ    = 4,
  parameter int RES_WIDTH  = res_width(DATA_WIDTH, NUM_INPUTS),
  parameter int TIMEOUT    = timeout_cycles(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         req_valid,
  output logic [NUM_REQ-1:0]                         req_ready,
  input  logic [NUM_REQ*NUM_INPUTS*DATA_WIDTH-1:0]   req_data,
  output logic                                       resp_valid,
  input  logic                                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                 resp_id,
  output logic [RES_WIDTH-1:0]                       resp_data,
  output logic                                       resp_err,
  output logic                                       mul_clr,
  output logic                                       mul_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]           mul_data,
  input  logic [RES_WIDTH-1:0]                       mul_result,
  input  logic                                       mul_done,
  output logic                                       busy
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int OPW = NUM_INPUTS * DATA_WIDTH;
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [IW-1:0]   last_grant;
  logic [CW-1:0]   run_cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            accept;
  logic            timeout_hit;

  dsc_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  assign accept      = (state == IDLE) && arb_any && !rst;
  assign timeout_hit = (run_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    mul_clr    = 1'b0;
    mul_en     = 1'b0;
    resp_valid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // Gate with rst so the grant never leaks out while held in reset.
        if (!rst) req_ready = arb_grant;
        if (accept) state_nx = CLEAR;
      end
      CLEAR: begin
        mul_clr  = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        mul_en = 1'b1;
        if (mul_done || timeout_hit) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IW'(NUM_REQ - 1);
      mul_data   <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      run_cnt    <= '0;
    end else begin
      if (accept) begin
        mul_data   <= req_data[int'(arb_idx)*OPW +: OPW];
        resp_id    <= arb_idx;
        last_grant <= arb_idx;
      end
      if (state == CLEAR) run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + CW'(1);
      // Done takes priority when it lands on the timeout cycle.
      if (state == RUN) begin
        if (mul_done) begin
          resp_data <= mul_result;
          resp_err  <= 1'b0;
        end else if (timeout_hit) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Directed and randomized bench for dsc_mul_sched with a latency-programmable core model.
module tb_dsc_mul_sched;

  localparam int DW      = 5;
  localparam int NI      = 2;
  localparam int NR      = 4;
  localparam int RW      = DW * NI + 1;
  localparam int TIMEOUT = (1 << (DW * NI)) + 16;
  localparam int OPW     = DW * NI;
  localparam int NEVER   = 1 << 30;

  logic              clk, rst;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*OPW-1:0] req_data;
  logic              resp_valid, resp_ready;
  logic [1:0]        resp_id;
  logic [RW-1:0]     resp_data;
  logic              resp_err, mul_clr, mul_en, busy;
  logic [OPW-1:0]    mul_data;
  logic [RW-1:0]     mul_result;
  logic              mul_done;

  int checks = 0;
  int errors = 0;
  int last_g;
  int lat_cur;
  bit spurious;
  int core_cnt;
  logic [RW-1:0] junk;
  logic          core_done;
  logic [RW-1:0] core_prod;

  dsc_mul_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .mul_clr(mul_clr), .mul_en(mul_en), .mul_data(mul_data),
    .mul_result(mul_result), .mul_done(mul_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: cleared by mul_clr|rst, done after lat_cur enabled cycles.
  always @(posedge clk) begin
    if (rst || mul_clr) core_cnt <= 0;
    else if (mul_en) core_cnt <= core_cnt + 1;
    junk <= RW'($urandom());
  end
  assign core_prod  = RW'(mul_data[DW-1:0]) * RW'(mul_data[OPW-1:DW]);
  assign core_done  = mul_en && (core_cnt == lat_cur);
  assign mul_done   = core_done || spurious;
  assign mul_result = core_done ? core_prod : junk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {req_ready, resp_valid, resp_id, resp_data, resp_err, mul_clr, mul_en, mul_data, busy};
  endfunction

  // One complete job; returns the granted requester.
  task automatic do_job(input logic [NR-1:0] mask, input int lat, input int bp,
                        input bit drop_valid, input bit use_fixed,
                        input logic [OPW-1:0] fixed_ops, output int g);
    logic [OPW-1:0] exp_ops;
    logic [RW-1:0]  prod, exp_data;
    bit             exp_err;
    int             n, bad, exp_n;
    g = -1;
    for (int k = 1; k <= NR; k++)
      if (g < 0 && mask[(last_g + k) % NR]) g = (last_g + k) % NR;
    lat_cur  = lat;
    req_data = (NR*OPW)'({$urandom(), $urandom()});
    if (use_fixed) req_data[g*OPW +: OPW] = fixed_ops;
    exp_ops  = req_data[g*OPW +: OPW];
    prod     = RW'(exp_ops[DW-1:0]) * RW'(exp_ops[OPW-1:DW]);
    req_valid = mask;
    #1 chk("grant", req_ready, 32'(1) << g);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    if (drop_valid) req_valid = '0;
    req_data = (NR*OPW)'({$urandom(), $urandom()});
    #1 chk("clear_clr", mul_clr, 1);
    chk("clear_en", mul_en, 0);
    chk("clear_ready", req_ready, 0);
    chk("mul_data", mul_data, exp_ops);
    @(posedge clk); #2;
    chk("en_rise", mul_en, 1);
    chk("clr_one_cycle", mul_clr, 0);
    n = 0; bad = 0;
    while (resp_valid !== 1'b1 && n < TIMEOUT + 8) begin
      if (mul_en !== 1'b1 || mul_data !== exp_ops || req_ready !== '0) bad++;
      @(posedge clk); #2;
      n++;
    end
    chk("run_hold", bad, 0);
    exp_err  = (lat > TIMEOUT - 1);
    exp_n    = exp_err ? TIMEOUT : lat + 1;
    exp_data = exp_err ? '0 : prod;
    chk("resp_latency", n, exp_n);
    chk("resp_id", resp_id, g);
    chk("resp_data", resp_data, exp_data);
    chk("resp_err", resp_err, exp_err);
    chk("resp_en_low", mul_en, 0);
    req_valid = '1;
    spurious  = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #2;
      chk("bp_valid", resp_valid, 1);
      chk("bp_fields", {resp_id, resp_data, resp_err}, {2'(g), exp_data, exp_err});
      chk("bp_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    spurious   = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    #1 chk("back_idle", busy, 0);
    chk("back_valid", resp_valid, 0);
    req_valid = '0;
    last_g = g;
  endtask

  initial begin
    int g;
    rst = 1'b1; req_valid = '1; req_data = '0; resp_ready = 1'b0;
    spurious = 1'b0; lat_cur = NEVER;
    #3 chk("reset_outs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; req_valid = '0; last_g = NR - 1;
    #1 chk("post_reset_busy", busy, 0);

    do_job(4'b0100, 1024, 0, 1'b1, 1'b1, {5'd20, 5'd12}, g);
    chk("single_grant", g, 2);
    do_job(4'b1011, NEVER, 0, 1'b0, 1'b0, '0, g);
    do_job(4'b0110, 7, 50, 1'b1, 1'b0, '0, g);
    do_job(4'b1000, TIMEOUT - 1, 1, 1'b0, 1'b0, '0, g);
    do_job(4'b0001, TIMEOUT, 0, 1'b0, 1'b0, '0, g);
    do_job(4'b0010, 0, 2, 1'b1, 1'b0, '0, g);

    // Abort a job with reset 100 cycles into RUN.
    lat_cur = NEVER;
    req_valid = 4'b0100;
    #1 chk("abort_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #1;
    repeat (100) @(posedge clk);
    #1 req_valid = '1;
    chk("abort_running", mul_en, 1);
    rst = 1'b1;
    #1 chk("abort_outs", all_outs(), 0);
    repeat (3) @(posedge clk);
    #1 chk("abort_no_resp", all_outs(), 0);
    rst = 1'b0; req_valid = '0; last_g = NR - 1;
    #1 chk("abort_idle", {busy, resp_valid}, 0);

    for (int j = 0; j < 8; j++) begin
      do_job(4'b1111, $urandom_range(0, 20), 0, 1'b0, 1'b0, '0, g);
      chk("fair_order", g, j % NR);
    end

    for (int j = 0; j < 12; j++) begin
      do_job(4'($urandom_range(1, 15)), $urandom_range(0, 40), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, '0, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
